mpc_vec_pingpong_buf: RTL and testbench
=======================================

# mpc_vec_pingpong_buf

Double-buffered vector memory serving the `ap_memory` ports of the ADMM vector stages. A producer loop (e.g. a vadd/vsub row pipeline) writes one vector through a single-port write interface (`address0/ce0/we0/d0`). A consumer loop reads the previous vector through a read interface with one-cycle `q0` latency. Bank ownership passes between the two sides with commit/release pulses, so a producer iteration k+1 overlaps a consumer iteration k without copying data.

## Interface
- `DW`, 32, element width (Q-format fixed point, opaque to this block)
- `AW`, 5, address width
- `DEPTH`, 24, elements per bank; must satisfy `DEPTH <= 2**AW`
- `ap_clk`  in  1  clock
- `ap_rst_n`  in  1  reset, asynchronous, active-low
- `wr_address0`  in  AW  producer element index
- `wr_ce0`  in  1  producer port enable
- `wr_we0`  in  1  producer write enable; a write occurs when `ce0 & we0`
- `wr_d0`  in  DW  producer write data
- `wr_commit`  in  1  producer finished the current vector; 1-cycle pulse
- `wr_ready`  out  1  the write bank is owned by the producer
- `rd_address0`  in  AW  consumer element index
- `rd_ce0`  in  1  consumer read enable
- `rd_q0`  out  DW  read data, valid one cycle after `rd_ce0`
- `rd_release`  in  1  consumer finished the current vector; 1-cycle pulse
- `rd_valid`  out  1  the read bank holds a committed vector
- `fill`  out  2  number of committed, unreleased banks (0..2)
- `err`  out  2  sticky flags: [0] write or commit while `!wr_ready`; [1] read or release while `!rd_valid`

## Operation
- Storage: two banks of `DEPTH` x `DW`. Each bank has a FULL bit. There are two 1-bit pointers: `wp` (write bank) and `rp` (read bank).
- `wr_ready = !FULL[wp]`; `rd_valid = FULL[rp]`; `fill = FULL[0] + FULL[1]`.
- Write: when `wr_ce0 & wr_we0 & wr_ready & (wr_address0 < DEPTH)`, store `wr_d0` to `bank[wp][wr_address0]`. Otherwise nothing is stored.
- Commit: when `wr_commit & wr_ready`, set `FULL[wp]` to 1 and toggle `wp`. A commit while `!wr_ready` is ignored.
- Read: when `rd_ce0`, register `rd_q0 <= bank[rp][rd_address0]`. If `rd_address0 >= DEPTH`, register 0 instead. Reads while `!rd_valid` still return bank contents (undefined data).
- Release: when `rd_release & rd_valid`, clear `FULL[rp]` and toggle `rp`. A release while `!rd_valid` is ignored.
- Hold: while `rd_ce0` is low, `rd_q0` holds its value.
- Error flags:
  - `err[0]` sets on (`wr_ce0 & wr_we0`) or `wr_commit` while `!wr_ready`.
  - `err[1]` sets on `rd_ce0` or `rd_release` while `!rd_valid`.
  - Both flags clear only on reset.
- Out-of-range addresses do not set `err`.
- Simultaneous events:
  - Commit and release in the same cycle are both applied from pre-edge state. With one bank FULL, the result is still one bank FULL.
  - A write and a commit in the same cycle: the write lands in the bank being committed (pre-toggle `wp`).
  - A read and a release in the same cycle: the read uses the pre-toggle `rp`.
- Memory contents are not reset and are not cleared on release.

## Timing
- Reset values (asynchronous assert, synchronous deassert at the next `ap_clk` edge):
  - `FULL = 00`, `wp = rp = 0`
  - `wr_ready = 1`, `rd_valid = 0`, `fill = 0`
  - `rd_q0 = 0`, `err = 0`
- Reset mid-vector discards both banks' ownership. The consumer must wait for a new commit.
- Write: 0-cycle acceptance, data stored at the clock edge.
- Read latency: exactly 1 cycle, from `rd_ce0` at edge n to `rd_q0` valid after edge n (usable in cycle n+1). This matches HLS `ap_memory` with latency 1.
- Commit to visibility: after the commit edge, `rd_valid` rises combinationally from the new `FULL` in the next cycle. The first read may be issued in that cycle, giving 1 cycle of commit-to-read latency.
- Release to write: `wr_ready` rises in the cycle after the release edge when `fill` was 2.
- Throughput: with both sides streaming, one element written and one element read per cycle. Steady state alternates banks with no bubbles beyond the commit/release cycle.
- Read-during-write on the same bank/address cannot occur legally, because the banks differ by ownership. If forced via the error path, the result is read-old-data.

## Test plan
- Single vector, in order:
  - Stimulus: reset; write `d = 100 + i` for `i = 0..23`; `wr_commit`; read `i = 0..23`.
  - Required: `rd_q0 = 100 + i` one cycle after each read; `fill` 0→1; `rd_valid = 1`; after `rd_release`, `fill = 0` and `rd_valid = 0`.
- Ping-pong overlap:
  - Stimulus: commit vector A (`0xA000 + i`); write vector B (`0xB000 + i`) while reading A; commit B; release A.
  - Required: reads return A values throughout; after the release, the next reads return B values; `fill` sequence 1, 2, 1.
- Back-pressure and error path:
  - Stimulus: commit two vectors (`fill = 2`); attempt a write `0xDEAD` to address 3 and a `wr_commit`.
  - Required: `wr_ready = 0`; `err = 01`; `fill` stays 2; bank data unchanged on later reads.
- Empty read:
  - Stimulus: after reset, assert `rd_ce0` and `rd_release`.
  - Required: `err[1] = 1`; `fill = 0`; `rp` is unchanged (the next committed vector is read from bank 0).
- Simultaneous and boundary events:
  - Stimulus: with `fill = 1`, pulse `wr_commit` and `rd_release` in the same cycle; read address 24 and address 31.
  - Required: `fill` stays 1; both out-of-range reads return 0 with `err` unchanged.
- Async reset mid-operation:
  - Stimulus: drop `ap_rst_n` between clock edges while `fill = 2` and `rd_q0 = 0x1234`.
  - Required: immediately `rd_q0 = 0`, `fill = 0`, `wr_ready = 1`, `rd_valid = 0`, `err = 0`.

Source files
------------

// File: rtl/mpc_vec_pingpong_buf_if.sv
// rtl/mpc_vec_pingpong_buf_if.sv - producer/consumer ports of the ping-pong vector buffer
interface mpc_vec_pingpong_buf_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] wr_address0;
    logic          wr_ce0;
    logic          wr_we0;
    logic [DW-1:0] wr_d0;
    logic          wr_commit;
    logic          wr_ready;
    logic [AW-1:0] rd_address0;
    logic          rd_ce0;
    logic [DW-1:0] rd_q0;
    logic          rd_release;
    logic          rd_valid;
    logic [1:0]    fill;
    logic [1:0]    err;

    // Producer/consumer loops drive the memory ports and pulses.
    modport master (
        output wr_address0, wr_ce0, wr_we0, wr_d0, wr_commit,
        output rd_address0, rd_ce0, rd_release,
        input  wr_ready, rd_q0, rd_valid, fill, err
    );

    // The buffer itself.
    modport slave (
        input  wr_address0, wr_ce0, wr_we0, wr_d0, wr_commit,
        input  rd_address0, rd_ce0, rd_release,
        output wr_ready, rd_q0, rd_valid, fill, err
    );
endinterface

// File: rtl/mpc_vec_pingpong_buf.sv
// rtl/mpc_vec_pingpong_buf.sv - double-buffered vector memory with commit/release ownership
module mpc_vec_pingpong_buf #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 24
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    mpc_vec_pingpong_buf_if.slave   bus
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Bank storage carries no reset; ownership lives entirely in full/wp/rp.
    logic [DW-1:0] bank_mem [2][DEPTH];

    logic [1:0]    full_q, full_d;
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [DW-1:0] rd_q0_q, rd_q0_d;
    logic [1:0]    err_q, err_d;

    logic          wr_ready;
    logic          rd_valid;
    logic          wr_hit;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          mem_we;

    // Next-state: ownership handoff, registered read port and sticky error flags.
    // Commit and release touch different FULL bits whenever both are legal,
    // so applying both from pre-edge state needs no special casing.
    always_comb begin
        wr_ready    = !full_q[wp_q];
        rd_valid    = full_q[rp_q];
        wr_hit      = bus.wr_ce0 & bus.wr_we0;
        wr_in_range = ({1'b0, bus.wr_address0} < DEPTH_W);
        rd_in_range = ({1'b0, bus.rd_address0} < DEPTH_W);
        mem_we      = wr_hit & wr_ready & wr_in_range;

        full_d  = full_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        rd_q0_d = rd_q0_q;
        err_d   = err_q;

        if (bus.wr_commit && wr_ready) begin
            full_d[wp_q] = 1'b1;
            wp_d         = ~wp_q;
        end
        if (bus.rd_release && rd_valid) begin
            full_d[rp_q] = 1'b0;
            rp_d         = ~rp_q;
        end

        // Read uses the pre-toggle rp and the pre-write memory (read-old-data).
        if (bus.rd_ce0) begin
            rd_q0_d = rd_in_range ? bank_mem[rp_q][bus.rd_address0] : '0;
        end

        if (!wr_ready && (wr_hit || bus.wr_commit)) begin
            err_d[0] = 1'b1;
        end
        if (!rd_valid && (bus.rd_ce0 || bus.rd_release)) begin
            err_d[1] = 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            full_q  <= 2'b00;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            rd_q0_q <= '0;
            err_q   <= 2'b00;
        end else begin
            full_q  <= full_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rd_q0_q <= rd_q0_d;
            err_q   <= err_d;
        end
    end

    // Producer write into the bank it currently owns (pre-toggle wp on a commit cycle).
    always_ff @(posedge ap_clk) begin
        if (mem_we) begin
            bank_mem[wp_q][bus.wr_address0] <= bus.wr_d0;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_q0    = rd_q0_q;
    assign bus.err      = err_q;
    assign bus.fill     = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_mpc_vec_pingpong_buf.sv
// tb/tb_mpc_vec_pingpong_buf.sv - self-checking bench for mpc_vec_pingpong_buf
module tb_mpc_vec_pingpong_buf;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 24;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    mpc_vec_pingpong_buf_if #(.DW(DW), .AW(AW)) bus ();

    mpc_vec_pingpong_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: commits/releases as running counts; bank = count mod 2.
    int          n_commit;
    int          n_release;
    logic [31:0] m_mem   [2][32];
    bit          m_known [2][32];
    logic [31:0] exp_q;
    bit          exp_q_known;
    logic [1:0]  exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n_commit    = 0;
        n_release   = 0;
        exp_q       = 0;
        exp_q_known = 1;
        exp_err     = 2'b00;
    endtask

    task automatic model_edge();
        int  f;
        bit  ok_w;
        bit  ok_r;
        int  wb;
        int  rb;
        f    = n_commit - n_release;
        ok_w = (f < 2);
        ok_r = (f > 0);
        wb   = n_commit % 2;
        rb   = n_release % 2;
        if (bus.rd_ce0) begin
            if (!ok_r) exp_err[1] = 1'b1;
            if (int'(bus.rd_address0) >= DEPTH) begin
                exp_q = 0;
                exp_q_known = 1;
            end else begin
                exp_q = m_mem[rb][bus.rd_address0];
                exp_q_known = m_known[rb][bus.rd_address0];
            end
        end
        if (bus.wr_ce0 && bus.wr_we0) begin
            if (!ok_w) exp_err[0] = 1'b1;
            else if (int'(bus.wr_address0) < DEPTH) begin
                m_mem[wb][bus.wr_address0]   = bus.wr_d0;
                m_known[wb][bus.wr_address0] = 1;
            end
        end
        if (bus.wr_commit) begin
            if (ok_w) n_commit++;
            else exp_err[0] = 1'b1;
        end
        if (bus.rd_release) begin
            if (ok_r) n_release++;
            else exp_err[1] = 1'b1;
        end
    endtask

    task automatic check_all();
        int f;
        f = n_commit - n_release;
        chk("fill", 32'(bus.fill), 32'(f));
        chk("wr_ready", 32'(bus.wr_ready), 32'(f < 2));
        chk("rd_valid", 32'(bus.rd_valid), 32'(f > 0));
        chk("err", 32'(bus.err), 32'(exp_err));
        if (exp_q_known) chk("rd_q0", bus.rd_q0, exp_q);
    endtask

    task automatic idle();
        bus.wr_address0 = '0;
        bus.wr_ce0      = 1'b0;
        bus.wr_we0      = 1'b0;
        bus.wr_d0       = '0;
        bus.wr_commit   = 1'b0;
        bus.rd_address0 = '0;
        bus.rd_ce0      = 1'b0;
        bus.rd_release  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        model_edge();
        #1;
        check_all();
        idle();
    endtask

    task automatic do_reset();
        idle();
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        model_reset();
        check_all();
        ap_rst_n = 1'b1;
    endtask

    task automatic set_wr(input int a, input logic [31:0] d);
        bus.wr_ce0      = 1'b1;
        bus.wr_we0      = 1'b1;
        bus.wr_address0 = AW'(a);
        bus.wr_d0       = d;
    endtask

    task automatic set_rd(input int a);
        bus.rd_ce0      = 1'b1;
        bus.rd_address0 = AW'(a);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 32; a++) begin
                m_mem[b][a] = '0;
                m_known[b][a] = 0;
            end
        idle();
        model_reset();

        // Reset state
        do_reset();
        chk("rst_fill", 32'(bus.fill), 32'd0);
        chk("rst_rd_q0", bus.rd_q0, 32'd0);

        // Single vector in order
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, 32'(100 + i));
            cyc();
        end
        bus.wr_commit = 1'b1;
        cyc();
        chk("sv_fill", 32'(bus.fill), 32'd1);
        chk("sv_rd_valid", 32'(bus.rd_valid), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(i);
            cyc();
            chk("sv_rd", bus.rd_q0, 32'(100 + i));
        end
        bus.rd_release = 1'b1;
        cyc();
        chk("sv_rel_fill", 32'(bus.fill), 32'd0);
        chk("sv_rel_valid", 32'(bus.rd_valid), 32'd0);

        // Ping-pong overlap: write B while reading A
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, 32'h0000_A000 + 32'(i));
            cyc();
        end
        bus.wr_commit = 1'b1;
        cyc();
        chk("pp_fill1", 32'(bus.fill), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, 32'h0000_B000 + 32'(i));
            set_rd(DEPTH - 1 - i);
            cyc();
            chk("pp_rdA", bus.rd_q0, 32'h0000_A000 + 32'(DEPTH - 1 - i));
        end
        bus.wr_commit = 1'b1;
        cyc();
        chk("pp_fill2", 32'(bus.fill), 32'd2);
        bus.rd_release = 1'b1;
        cyc();
        chk("pp_fill3", 32'(bus.fill), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_rd(i * 5);
            cyc();
            chk("pp_rdB", bus.rd_q0, 32'h0000_B000 + 32'(i * 5));
        end

        // Back-pressure: second vector committed, then illegal write and commit
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, $urandom);
            cyc();
        end
        bus.wr_commit = 1'b1;
        cyc();
        chk("bp_fill", 32'(bus.fill), 32'd2);
        chk("bp_ready", 32'(bus.wr_ready), 32'd0);
        set_wr(3, 32'h0000_DEAD);
        bus.wr_commit = 1'b1;
        cyc();
        chk("bp_err", 32'(bus.err), 32'b01);
        chk("bp_fill_hold", 32'(bus.fill), 32'd2);
        set_rd(3);
        cyc();
        chk("bp_rdB3", bus.rd_q0, 32'h0000_B003);
        bus.rd_release = 1'b1;
        cyc();
        set_rd(3);
        cyc();

        // Simultaneous commit/release with fill=1, then out-of-range reads
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, $urandom);
            cyc();
        end
        bus.wr_commit  = 1'b1;
        bus.rd_release = 1'b1;
        cyc();
        chk("sim_fill", 32'(bus.fill), 32'd1);
        set_rd(24);
        cyc();
        chk("oor24", bus.rd_q0, 32'd0);
        set_rd(5);
        cyc();
        set_rd(31);
        cyc();
        chk("oor31", bus.rd_q0, 32'd0);
        chk("oor_err", 32'(bus.err), 32'b01);

        // Empty read/release after reset; next vector must come from bank 0
        do_reset();
        set_rd(2);
        bus.rd_release = 1'b1;
        cyc();
        chk("empty_err", 32'(bus.err), 32'b10);
        chk("empty_fill", 32'(bus.fill), 32'd0);
        set_wr(0, 32'h0000_5A5A);
        bus.wr_commit = 1'b1;
        cyc();
        set_rd(0);
        cyc();
        chk("empty_rp0", bus.rd_q0, 32'h0000_5A5A);
        set_rd(5);
        cyc();
        bus.rd_release = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.wr_ce0      = ($urandom_range(0, 1) == 1);
            bus.wr_we0      = ($urandom_range(0, 3) != 0);
            bus.wr_address0 = AW'($urandom_range(0, 31));
            bus.wr_d0       = $urandom;
            bus.wr_commit   = ($urandom_range(0, 15) == 0);
            bus.rd_ce0      = ($urandom_range(0, 1) == 1);
            bus.rd_address0 = AW'($urandom_range(0, 31));
            bus.rd_release  = ($urandom_range(0, 15) == 0);
            cyc();
        end

        // Asynchronous reset with fill=2 and rd_q0=0x1234
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, (i == 7) ? 32'h0000_1234 : $urandom);
            cyc();
        end
        bus.wr_commit = 1'b1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, $urandom);
            cyc();
        end
        bus.wr_commit = 1'b1;
        cyc();
        set_wr(1, 32'h0000_DEAD);
        set_rd(7);
        cyc();
        chk("ar_pre_q", bus.rd_q0, 32'h0000_1234);
        chk("ar_pre_fill", 32'(bus.fill), 32'd2);
        chk("ar_pre_err", 32'(bus.err), 32'b01);
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("ar_q", bus.rd_q0, 32'd0);
        chk("ar_fill", 32'(bus.fill), 32'd0);
        chk("ar_ready", 32'(bus.wr_ready), 32'd1);
        chk("ar_valid", 32'(bus.rd_valid), 32'd0);
        chk("ar_err", 32'(bus.err), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        model_reset();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
